rs_integer: RTL
===============

RS_INTEGER -- requirements
Module: rs_integer

Interface
REQ-001 Parameter: DEPTH, default 4, number of station entries (2..8).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 res_n  in  1  reset, asynchronous, active-low.
REQ-004 valid_disp2rs  in  1  dispatch request this cycle.
REQ-005 opcode_disp2rs  in  7  opcode of dispatched instruction.
REQ-006 a_val_disp2rs, b_val_disp2rs  in  64 each  operand values, meaningful when the matching ready bit is 1.
REQ-007 a_rdy_disp2rs, b_rdy_disp2rs  in  1 each  operand already available.
REQ-008 a_tag_disp2rs, b_tag_disp2rs  in  6 each  producer ROB tag, used when the matching ready bit is 0.
REQ-009 rd_disp2rs, tag_disp2rs  in  6 each  destination register, own ROB tag.
REQ-010 full_rs2disp  out  1  all DEPTH entries occupied.
REQ-011 cdb_valid, cdb_tag, cdb_result  in  1/6/64  result broadcast (wakeup).
REQ-012 flush_rob2rs  in  1  discard all entries.
REQ-013 valid_rs2int  out  1  issue strobe to integer unit.
REQ-014 opcode_rs2int, a_rs2int, b_rs2int, rd_rs2int, tag_rs2int  out  7/64/64/6/6  issued instruction fields.
REQ-015 stop_int2rsint  in  1  integer unit cannot accept an issue.

Function
REQ-016 Each entry SHALL hold: busy, opcode, rd, tag, and per operand value/tag/ready.
REQ-017 full_rs2disp SHALL be combinational from the registered busy bits: 1 iff all entries are busy.
REQ-018 Dispatch SHALL be accepted iff valid_disp2rs=1, full_rs2disp=0, flush_rob2rs=0; the entry is allocated to the lowest-index non-busy entry.
REQ-019 Dispatch while full SHALL be ignored with no state change; an entry freed by issue on the same edge SHALL NOT be reusable until the next cycle.
REQ-020 Wakeup: on each edge with cdb_valid=1, every busy entry operand with ready=0 and tag=cdb_tag SHALL capture cdb_result and set ready=1.
REQ-021 Dispatch bypass: a dispatched operand with ready=0 whose tag equals cdb_tag while cdb_valid=1 SHALL be stored with cdb_result and ready=1.
REQ-022 Issue selection SHALL use registered state only: candidate = busy entry with both ready bits 1; the lowest-index candidate is selected.
REQ-023 An entry dispatched or woken on edge N SHALL first be selectable for the issue registered on edge N+1 (minimum dispatch-to-valid_rs2int latency: 1 cycle after dispatch edge, with ready operands).
REQ-024 If stop_int2rsint=0 and a candidate exists: on the edge, output fields SHALL load from that entry, valid_rs2int<=1, entry busy<=0.
REQ-025 If stop_int2rsint=1 or no candidate: valid_rs2int<=0, no entry freed; other output fields hold their prior value.
REQ-026 At most one issue per cycle; issue and dispatch and wakeup on the same edge SHALL all take effect, on distinct entries.
REQ-027 flush_rob2rs=1 SHALL, on the edge, clear all busy bits and valid_rs2int, overriding dispatch, wakeup and issue.
REQ-028 Operands are passed through unmodified; no arithmetic in this block.

Reset
REQ-029 While res_n=0: all busy/ready bits 0, valid_rs2int=0, opcode/a/b/rd/tag_rs2int=0, full_rs2disp=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately; first dispatch is accepted on the first edge after release.

Verification
REQ-031 Dispatch ADD a=5,b=7 both ready, tag=3, rd=9 at edge 0 -> edge 1: valid_rs2int=1, a=5, b=7, tag=3, rd=9; edge 2: valid_rs2int=0.
REQ-032 Dispatch a_rdy=0 a_tag=12; 3 cycles later cdb_valid=1 tag=12 result=0x100 -> valid_rs2int one edge after wakeup with a_rs2int=0x100.
REQ-033 Dispatch a_rdy=0 a_tag=4 in same cycle as cdb tag=4 result=42 -> issued next edge with a=42 (bypass).
REQ-034 stop_int2rsint=1, dispatch 4 ready entries -> full_rs2disp=1, 5th dispatch ignored, valid_rs2int=0; release stop -> entries 0,1,2,3 issue on 4 consecutive edges.
REQ-035 3 entries busy, assert flush_rob2rs for one cycle -> next edge all empty, valid_rs2int=0, no later issue; reset mid-issue -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rs_integer.sv
// rs_integer: reservation station for the integer unit.
// Holds up to DEPTH dispatched instructions, captures operands from the CDB
// (including a same-cycle bypass at dispatch), and issues one ready entry
// per cycle. The lowest index wins both allocation and issue.
module rs_integer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        res_n,
    // dispatch
    input  logic        valid_disp2rs,
    input  logic [6:0]  opcode_disp2rs,
    input  logic [63:0] a_val_disp2rs,
    input  logic [63:0] b_val_disp2rs,
    input  logic        a_rdy_disp2rs,
    input  logic        b_rdy_disp2rs,
    input  logic [5:0]  a_tag_disp2rs,
    input  logic [5:0]  b_tag_disp2rs,
    input  logic [5:0]  rd_disp2rs,
    input  logic [5:0]  tag_disp2rs,
    output logic        full_rs2disp,
    // result broadcast
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [63:0] cdb_result,
    // flush
    input  logic        flush_rob2rs,
    // issue
    output logic        valid_rs2int,
    output logic [6:0]  opcode_rs2int,
    output logic [63:0] a_rs2int,
    output logic [63:0] b_rs2int,
    output logic [5:0]  rd_rs2int,
    output logic [5:0]  tag_rs2int,
    input  logic        stop_int2rsint
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // entry storage
    logic        r_busy   [DEPTH];
    logic [6:0]  r_opcode [DEPTH];
    logic [5:0]  r_rd     [DEPTH];
    logic [5:0]  r_tag    [DEPTH];
    logic [63:0] r_a_val  [DEPTH];
    logic [63:0] r_b_val  [DEPTH];
    logic [5:0]  r_a_tag  [DEPTH];
    logic [5:0]  r_b_tag  [DEPTH];
    logic        r_a_rdy  [DEPTH];
    logic        r_b_rdy  [DEPTH];

    // issue output registers
    logic        r_valid;
    logic [6:0]  r_out_opcode;
    logic [63:0] r_out_a;
    logic [63:0] r_out_b;
    logic [5:0]  r_out_rd;
    logic [5:0]  r_out_tag;

    logic [DEPTH-1:0] w_busy;
    logic [DEPTH-1:0] w_cand;
    logic [IDXW-1:0]  w_free_idx;
    logic [IDXW-1:0]  w_cand_idx;
    logic             w_full;
    logic             w_disp;
    logic             w_issue;
    logic             w_a_byp;
    logic             w_b_byp;
    logic             w_disp_a_rdy;
    logic             w_disp_b_rdy;
    logic [63:0]      w_disp_a_val;
    logic [63:0]      w_disp_b_val;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flags
            assign w_busy[gi] = r_busy[gi];
            assign w_cand[gi] = r_busy[gi] & r_a_rdy[gi] & r_b_rdy[gi];
        end
    endgenerate

    assign w_full  = &w_busy;
    assign w_disp  = valid_disp2rs & ~w_full & ~flush_rob2rs;
    assign w_issue = ~stop_int2rsint & (|w_cand) & ~flush_rob2rs;

    // a waiting operand whose producer is broadcasting right now is stored as ready
    assign w_a_byp      = ~a_rdy_disp2rs & cdb_valid & (a_tag_disp2rs == cdb_tag);
    assign w_b_byp      = ~b_rdy_disp2rs & cdb_valid & (b_tag_disp2rs == cdb_tag);
    assign w_disp_a_rdy = a_rdy_disp2rs | w_a_byp;
    assign w_disp_b_rdy = b_rdy_disp2rs | w_b_byp;
    assign w_disp_a_val = a_rdy_disp2rs ? a_val_disp2rs : cdb_result;
    assign w_disp_b_val = b_rdy_disp2rs ? b_val_disp2rs : cdb_result;

    // lowest-index free entry and lowest-index issue candidate
    always_comb begin
        w_free_idx = '0;
        w_cand_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_busy[i]) w_free_idx = IDXW'(i);
            if (w_cand[i])  w_cand_idx = IDXW'(i);
        end
    end

    // entry state: flush beats everything; otherwise issue, wakeup and
    // dispatch act on distinct entries (dispatch only targets a free one)
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]   <= 1'b0;
                r_opcode[i] <= '0;
                r_rd[i]     <= '0;
                r_tag[i]    <= '0;
                r_a_val[i]  <= '0;
                r_b_val[i]  <= '0;
                r_a_tag[i]  <= '0;
                r_b_tag[i]  <= '0;
                r_a_rdy[i]  <= 1'b0;
                r_b_rdy[i]  <= 1'b0;
            end
        end else if (flush_rob2rs) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue && (w_cand_idx == IDXW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
                if (r_busy[i] && cdb_valid && !r_a_rdy[i] && (r_a_tag[i] == cdb_tag)) begin
                    r_a_val[i] <= cdb_result;
                    r_a_rdy[i] <= 1'b1;
                end
                if (r_busy[i] && cdb_valid && !r_b_rdy[i] && (r_b_tag[i] == cdb_tag)) begin
                    r_b_val[i] <= cdb_result;
                    r_b_rdy[i] <= 1'b1;
                end
                if (w_disp && (w_free_idx == IDXW'(i))) begin
                    r_busy[i]   <= 1'b1;
                    r_opcode[i] <= opcode_disp2rs;
                    r_rd[i]     <= rd_disp2rs;
                    r_tag[i]    <= tag_disp2rs;
                    r_a_val[i]  <= w_disp_a_val;
                    r_b_val[i]  <= w_disp_b_val;
                    r_a_tag[i]  <= a_tag_disp2rs;
                    r_b_tag[i]  <= b_tag_disp2rs;
                    r_a_rdy[i]  <= w_disp_a_rdy;
                    r_b_rdy[i]  <= w_disp_b_rdy;
                end
            end
        end
    end

    // issue register: strobe follows the issue decision, fields hold when idle
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_valid      <= 1'b0;
            r_out_opcode <= '0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_rd     <= '0;
            r_out_tag    <= '0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_out_opcode <= r_opcode[w_cand_idx];
                r_out_a      <= r_a_val[w_cand_idx];
                r_out_b      <= r_b_val[w_cand_idx];
                r_out_rd     <= r_rd[w_cand_idx];
                r_out_tag    <= r_tag[w_cand_idx];
            end
        end
    end

    assign full_rs2disp  = w_full;
    assign valid_rs2int  = r_valid;
    assign opcode_rs2int = r_out_opcode;
    assign a_rs2int      = r_out_a;
    assign b_rs2int      = r_out_b;
    assign rd_rs2int     = r_out_rd;
    assign tag_rs2int    = r_out_tag;

endmodule
